vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Consumes the 25 MHz pixel clock and the raw PLL lock flag from the board PLL wrapper.
- Generates 640x480@60 VGA raster timing: sync pulses, data-enable, pixel coordinates and frame/line strobes.
- Holds the raster idle until lock has been stable for a settle window. Returns to idle on any loss of lock.
- Sits between the PLL wrapper and the pixel/framebuffer logic.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in clocks
- H_SYNC, 96, hsync width in clocks
- H_BP, 48, horizontal back porch in clocks
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vsync width in lines
- V_BP, 33, vertical back porch in lines
- SYNC_ACTIVE_LOW, 1, 1 = hsync/vsync asserted low
- LOCK_SETTLE, 1024, consecutive synced-lock cycles required before raster runs (>=1)
- CW, 10, coordinate/counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  input  1  pixel clock, 25 MHz
- nrst  input  1  asynchronous active-low reset
- pll_locked  input  1  raw PLL lock, asynchronous to clk
- running  output  1  raster enabled (lock qualified)
- hsync  output  1  horizontal sync, polarity per SYNC_ACTIVE_LOW
- vsync  output  1  vertical sync, polarity per SYNC_ACTIVE_LOW
- de  output  1  visible-pixel data enable
- x  output  CW  pixel column, valid when de=1
- y  output  CW  pixel row, valid when de=1
- line_start  output  1  one-cycle pulse on x=0 of each visible line
- frame_start  output  1  one-cycle pulse on x=0,y=0

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset (nrst low, async):
  - FSM=WAIT_LOCK, settle counter=0, hcnt=vcnt=0.
  - running=0, de=0, x=0, y=0, line_start=0, frame_start=0.
  - hsync/vsync at inactive level (1 if SYNC_ACTIVE_LOW).
- Lock sync: pll_locked passes through a 2-flop synchronizer to give lk; lk reset value is 0.
- Lock FSM:
  - WAIT_LOCK: when lk=1, go to SETTLE with settle counter=1.
  - SETTLE: while lk=1, counter increments. When counter=LOCK_SETTLE, go to RUN. If lk=0, return to WAIT_LOCK and clear the counter.
  - RUN: running=1. If lk=0, go to WAIT_LOCK next cycle; running, de and strobes drop that cycle.
  - Net latency from pll_locked rise to running=1 is 2+LOCK_SETTLE cycles.
- Counters (advance only in RUN):
  - hcnt wraps H_TOTAL-1 to 0.
  - vcnt increments on hcnt wrap and wraps V_TOTAL-1 to 0.
  - Outside RUN, both are held at 0, so each RUN entry starts at pixel (0,0).
- Decode: all outputs are registered, one cycle behind the counters, and mutually aligned.
  - de = (hcnt<H_ACTIVE) && (vcnt<V_ACTIVE).
  - hsync asserted for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) = [656,752).
  - vsync asserted for vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC) = [490,492), over whole lines.
  - x=hcnt and y=vcnt when de=1; otherwise x and y hold 0.
  - line_start = de && hcnt==0; frame_start = line_start && vcnt==0.
- Simultaneous events: lk falling on the wrap cycle means lock loss wins; no strobe is emitted.
- Reset mid-frame forces the reset values immediately.
- Outside RUN, hsync and vsync sit at their inactive levels.

Decomposition:
- Package vga_timing_pkg holds:
  - 640x480@60 default constants and H_TOTAL/V_TOTAL functions
  - lock FSM state enum {WAIT_LOCK, SETTLE, RUN}
  - CW
- One sub-module, lock_qualifier: synchronizer, settle counter and FSM; outputs the run enable.
- The top level holds the counters and the output decode.

Test Plan:
- Reset values: hold nrst=0 with pll_locked=1 → running=0, de=0, x=y=0, hsync=vsync=1, strobes 0. Release nrst → running rises exactly 2+1024 cycles later.
- First frame: after running rises → frame_start on the first de cycle with x=0,y=0.
  - de high 640 cycles per line, then low 160.
  - hsync low for 96 cycles, starting 656 cycles after line_start.
  - Next frame_start exactly 420000 cycles later.
- Vertical timing:
  - vsync low for exactly 1600 cycles (2 lines), starting 490*800 cycles after frame_start.
  - 480 line_start pulses per frame.
  - y increments 0..479 with no de during lines 480..524.
- Settle glitch: pll_locked drops for 3 cycles at settle count 500 → FSM returns to WAIT_LOCK; running rises 2+1024 cycles after the second rise.
- Mid-frame lock loss: drop pll_locked at pixel (300,200) → running and de go 0 within 3 cycles, hsync/vsync inactive. After relock and settle, the raster restarts with frame_start at (0,0).
- Async reset mid-line: assert nrst between clock edges during de → outputs reach reset values before the next edge; normal restart afterwards.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared constants, totals helpers and lock FSM state type for the
// 640x480@60 VGA timing generator.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE    = 640;
    localparam int DEF_H_FP        = 16;
    localparam int DEF_H_SYNC      = 96;
    localparam int DEF_H_BP        = 48;
    localparam int DEF_V_ACTIVE    = 480;
    localparam int DEF_V_FP        = 10;
    localparam int DEF_V_SYNC      = 2;
    localparam int DEF_V_BP        = 33;
    localparam int DEF_LOCK_SETTLE = 1024;
    localparam int DEF_CW          = 10;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        SETTLE,
        RUN
    } lock_state_t;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle: the generator drives it (master), pixel and
// framebuffer logic consume it (slave).
interface vga_timing_gen_if
    import vga_timing_pkg::*;
#(
    parameter int CW = DEF_CW
);
    logic          running;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          line_start;
    logic          frame_start;

    modport master (
        output running, hsync, vsync, de, x, y, line_start, frame_start
    );

    modport slave (
        input running, hsync, vsync, de, x, y, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen_lock_qualifier.sv
// Synchronises the raw PLL lock and enables the raster only after lock has
// been continuously present for LOCK_SETTLE synchronised cycles.
module lock_qualifier
    import vga_timing_pkg::*;
#(
    parameter int LOCK_SETTLE = DEF_LOCK_SETTLE
) (
    input  logic clk,
    input  logic nrst,
    input  logic pll_locked_i,
    output logic running_o,
    output logic run_en_o
);
    localparam int              SW          = $clog2(LOCK_SETTLE + 1);
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(LOCK_SETTLE - 1);

    logic          sync_q;
    logic          lk_q;
    lock_state_t   state_q;
    logic [SW-1:0] cnt_q;
    logic          running_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_q <= 1'b0;
            lk_q   <= 1'b0;
        end else begin
            sync_q <= pll_locked_i;
            lk_q   <= sync_q;
        end
    end

    // RUN is entered on the edge where the settle count reaches LOCK_SETTLE,
    // so the raster enables LOCK_SETTLE cycles after lk first reads high.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            running_q <= 1'b0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (lk_q) begin
                        cnt_q <= SW'(1);
                        if (LOCK_SETTLE == 1) begin
                            state_q   <= RUN;
                            running_q <= 1'b1;
                        end else begin
                            state_q <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (!lk_q) begin
                        state_q <= WAIT_LOCK;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + SW'(1);
                        if (cnt_q == SETTLE_LAST) begin
                            state_q   <= RUN;
                            running_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!lk_q) begin
                        state_q   <= WAIT_LOCK;
                        running_q <= 1'b0;
                        cnt_q     <= '0;
                    end
                end
                default: begin
                    state_q   <= WAIT_LOCK;
                    running_q <= 1'b0;
                    cnt_q     <= '0;
                end
            endcase
        end
    end

    assign running_o = running_q;
    // Gating with lk lets a lock loss stop the raster on the same edge the FSM leaves RUN.
    assign run_en_o  = running_q & lk_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: lock-qualified enable drives the pixel/line counters,
// whose decode is registered one cycle behind onto the output interface.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE        = DEF_H_ACTIVE,
    parameter int H_FP            = DEF_H_FP,
    parameter int H_SYNC          = DEF_H_SYNC,
    parameter int H_BP            = DEF_H_BP,
    parameter int V_ACTIVE        = DEF_V_ACTIVE,
    parameter int V_FP            = DEF_V_FP,
    parameter int V_SYNC          = DEF_V_SYNC,
    parameter int V_BP            = DEF_V_BP,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int LOCK_SETTLE     = DEF_LOCK_SETTLE,
    parameter int CW              = DEF_CW
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             pll_locked,
    vga_timing_gen_if.master vga_o
);
    localparam int            H_TOTAL   = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int            V_TOTAL   = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS     = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS     = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END    = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END    = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

    logic          running;
    logic          run_en;
    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [CW-1:0] vcnt_q, vcnt_d;
    logic          de_q, de_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic          visible;
    logic          hs_act;
    logic          vs_act;

    lock_qualifier #(
        .LOCK_SETTLE (LOCK_SETTLE)
    ) u_lock_qualifier (
        .clk          (clk),
        .nrst         (nrst),
        .pll_locked_i (pll_locked),
        .running_o    (running),
        .run_en_o     (run_en)
    );

    // Counters collapse to the origin whenever the raster is not enabled.
    always_comb begin
        hcnt_d = '0;
        vcnt_d = '0;
        if (run_en) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + CW'(1);
            end else begin
                hcnt_d = hcnt_q + CW'(1);
                vcnt_d = vcnt_q;
            end
        end
    end

    always_comb begin
        visible       = run_en && (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
        hs_act        = run_en && (hcnt_q >= HS_START) && (hcnt_q < HS_END);
        vs_act        = run_en && (vcnt_q >= VS_START) && (vcnt_q < VS_END);
        de_d          = visible;
        x_d           = visible ? hcnt_q : '0;
        y_d           = visible ? vcnt_q : '0;
        hsync_d       = hs_act ? ~SYNC_IDLE : SYNC_IDLE;
        vsync_d       = vs_act ? ~SYNC_IDLE : SYNC_IDLE;
        line_start_d  = visible && (hcnt_q == '0);
        frame_start_d = visible && (hcnt_q == '0) && (vcnt_q == '0);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            de_q          <= 1'b0;
            hsync_q       <= SYNC_IDLE;
            vsync_q       <= SYNC_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga_o.running     = running;
    assign vga_o.hsync       = hsync_q;
    assign vga_o.vsync       = vsync_q;
    assign vga_o.de          = de_q;
    assign vga_o.x           = x_q;
    assign vga_o.y           = y_q;
    assign vga_o.line_start  = line_start_q;
    assign vga_o.frame_start = frame_start_q;

endmodule
